// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the cache-side SRAM controller.
// The halfword-address helper keeps the byte-to-SRAM mapping in one place.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          WRITE_BEATS       = 2;
    localparam int          READ_BEATS        = 4;
    localparam int          SRAM_AW           = 18;
    localparam int          SRAM_DW           = 16;

    // Byte offset from the window base, halved and wrapped to the SRAM address space.
    function automatic logic [SRAM_AW-1:0] halfword_addr(input logic [31:0] addr,
                                                         input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset[SRAM_AW:1];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Cache-to-SRAM request bus: the cache controller is the master, the SRAM
// controller the slave. ready is combinational on the slave side.
interface sram_controller_if;

    logic [31:0] address;
    logic [31:0] writeData;
    logic        wrEn;
    logic        rdEn;
    logic [63:0] readData;
    logic        ready;

    modport master (
        output address, writeData, wrEn, rdEn,
        input  readData, ready
    );

    modport slave (
        input  address, writeData, wrEn, rdEn,
        output readData, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Sequences single-word writes (2 halfwords) and 64-bit block reads (4 halfwords)
// onto a 16-bit asynchronous SRAM; all SRAM pins come straight from flops.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int             CW       = $clog2(ACCESS_CYCLES);
    localparam logic [CW-1:0]  CYC_LAST = CW'(ACCESS_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [SRAM_AW-1:0] base_q, base_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         last_beat;

    logic [63:0]        rdata_q;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic               we_n_q;
    logic               oe_n_q;
    logic               drive_q;
    logic [SRAM_DW-1:0] dq_out_q;

    assign last_beat = (state_q == WRITE) ? 2'(WRITE_BEATS - 1) : 2'(READ_BEATS - 1);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cyc_d   = cyc_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wrEn) begin
                    state_d = WRITE;
                    base_d  = halfword_addr(bus.address, BASE_ADDR);
                    wdata_d = bus.writeData;
                    beat_d  = '0;
                    cyc_d   = '0;
                end else if (bus.rdEn) begin
                    state_d = READ;
                    base_d  = {halfword_addr(bus.address, BASE_ADDR) >> 2, 2'b00};
                    beat_d  = '0;
                    cyc_d   = '0;
                end
            end
            WRITE, READ: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (beat_q == last_beat) begin
                        state_d = DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            cyc_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b0;
            drive_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cyc_q   <= cyc_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            // Pin flops load from next-state so each beat's pins are valid for its whole first cycle.
            if (state_d == WRITE || state_d == READ)
                sram_addr_q <= base_d + SRAM_AW'(beat_d);
            we_n_q   <= !(state_d == WRITE && cyc_d != CYC_LAST);
            oe_n_q   <= (state_d == WRITE);
            drive_q  <= (state_d == WRITE);
            dq_out_q <= beat_d[0] ? wdata_d[31:16] : wdata_d[15:0];
            if (state_q == READ && cyc_q == CYC_LAST)
                rdata_q[{beat_q, 4'b0000} +: 16] <= SRAM_DQ;
        end
    end

    assign SRAM_DQ      = drive_q ? dq_out_q : 'z;
    assign SRAM_ADDR    = sram_addr_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_CE_N    = 1'b0;
    assign SRAM_UB_N    = 1'b0;
    assign SRAM_LB_N    = 1'b0;

    assign bus.readData = rdata_q;
    assign bus.ready    = ~(bus.wrEn | bus.rdEn) | (state_q == DONE);

endmodule
